// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and the transmit feeder state type
package uart_pkg;

    localparam int SYSTEM_CLOCK          = 32_000_000;
    localparam int BAUD_RATE             = 9600;
    localparam int DEPTH_DEFAULT         = 16;
    localparam int START_TIMEOUT_DEFAULT = 64;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        START      = 2'd1,
        IDLE_RETRY = 2'd2,
        BUSY       = 2'd3
    } feeder_state_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock circular byte FIFO with explicit occupancy counter
module sync_fifo #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_wr_en,
    input  logic [7:0]        i_wr_data,
    input  logic              i_rd_en,
    output logic [7:0]        o_rd_data,
    output logic              o_full,
    output logic              o_empty,
    output logic [ADDR_W:0]   o_level
);

    logic [7:0]      r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_level;
    logic              w_push;
    logic              w_pop;

    // A pop never frees room for a same-cycle push: acceptance looks only at full.
    assign w_push = i_wr_en && !o_full;
    assign w_pop  = i_rd_en && !o_empty;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_wr_data;
    end

    assign o_rd_data = r_mem[r_rd_ptr];
    assign o_level   = r_level;
    assign o_full    = (r_level == (ADDR_W+1)'(DEPTH));
    assign o_empty   = (r_level == '0);

endmodule

// File: rtl/uart_tx_feeder.sv
// rtl/uart_tx_feeder.sv - byte FIFO and launch FSM driving uart_tx en/data_in
module uart_tx_feeder
    import uart_pkg::*;
#(
    parameter int DEPTH         = DEPTH_DEFAULT,
    parameter int ADDR_W        = 4,
    parameter int START_TIMEOUT = START_TIMEOUT_DEFAULT
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_wr_en,
    input  logic [7:0]      i_wr_data,
    output logic            o_full,
    output logic            o_empty,
    output logic [ADDR_W:0] o_level,
    output logic            o_overflow,
    output logic            o_tx_stall,
    input  logic            i_clr_flags,
    output logic            o_tx_en,
    output logic [7:0]      o_tx_data,
    input  logic            i_tx_rdy
);

    localparam int CNT_W = (START_TIMEOUT > 2) ? $clog2(START_TIMEOUT) : 1;

    feeder_state_t r_state;
    feeder_state_t w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [7:0]       r_tx_data;
    logic             r_overflow;
    logic             r_tx_stall;
    logic             w_pop;
    logic             w_cnt_inc;
    logic             w_cnt_clr;
    logic             w_stall_set;
    logic             w_tx_en;
    logic [7:0]       w_rd_data;
    logic             w_full;
    logic             w_empty;

    sync_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_wr_en   (i_wr_en),
        .i_wr_data (i_wr_data),
        .i_rd_en   (w_pop),
        .o_rd_data (w_rd_data),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_level   (o_level)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_tx_data  <= 8'h00;
            r_overflow <= 1'b0;
            r_tx_stall <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_cnt_clr)      r_cnt <= '0;
            else if (w_cnt_inc) r_cnt <= r_cnt + 1'b1;
            if (w_pop) r_tx_data <= w_rd_data;
            if (i_clr_flags) begin
                r_overflow <= 1'b0;
                r_tx_stall <= 1'b0;
            end else begin
                if (i_wr_en && w_full) r_overflow <= 1'b1;
                if (w_stall_set)       r_tx_stall <= 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_cnt_inc   = 1'b0;
        w_cnt_clr   = 1'b0;
        w_stall_set = 1'b0;
        w_tx_en     = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty && i_tx_rdy) begin
                    w_pop       = 1'b1;
                    w_state_nxt = START;
                end
            end
            START: begin
                w_tx_en = 1'b1;
                if (!i_tx_rdy) begin
                    w_cnt_clr   = 1'b1;
                    w_state_nxt = BUSY;
                end else if (r_cnt == CNT_W'(START_TIMEOUT - 1)) begin
                    // Transmitter never acknowledged: back off one cycle and relaunch the same byte.
                    w_cnt_clr   = 1'b1;
                    w_stall_set = 1'b1;
                    w_state_nxt = IDLE_RETRY;
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
            IDLE_RETRY: begin
                w_state_nxt = START;
            end
            BUSY: begin
                if (i_tx_rdy) w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign o_tx_en    = w_tx_en;
    assign o_tx_data  = r_tx_data;
    assign o_full     = w_full;
    assign o_empty    = w_empty;
    assign o_overflow = r_overflow;
    assign o_tx_stall = r_tx_stall;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb/tb_uart_tx_feeder.sv - self-checking bench for uart_tx_feeder with a behavioural transmitter
`timescale 1ns/1ps
module tb_uart_tx_feeder;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       clr_flags = 1'b0;
    logic       tx_rdy = 1'b1;
    logic       full, empty, overflow, tx_stall, tx_en;
    logic [4:0] level;
    logic [7:0] tx_data;

    int tests = 0;
    int fails = 0;

    logic [7:0] exp_q[$];
    logic [7:0] rcv_q[$];

    // transmitter model controls
    logic stuck = 1'b0;
    logic hold  = 1'b0;
    int   bmin  = 2;
    int   bmax  = 10;
    int   busy_left = 0;
    int   violations = 0;
    logic prev_en_low_rdy = 1'b0;
    logic prev_en = 1'b0;
    logic [7:0] prev_data = 8'h00;

    always #15.625 clk = ~clk;

    uart_tx_feeder dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_wr_en     (wr_en),
        .i_wr_data   (wr_data),
        .o_full      (full),
        .o_empty     (empty),
        .o_level     (level),
        .o_overflow  (overflow),
        .o_tx_stall  (tx_stall),
        .i_clr_flags (clr_flags),
        .o_tx_en     (tx_en),
        .o_tx_data   (tx_data),
        .i_tx_rdy    (tx_rdy)
    );

    // Behavioural uart_tx: accepts a byte when en is seen while idle, then stays busy a random time.
    always @(posedge clk) begin
        if (rst_n) begin
            if (tx_en && !tx_rdy && prev_en_low_rdy) violations <= violations + 1;
            if (tx_en && prev_en && tx_data !== prev_data) violations <= violations + 1;
        end
        prev_en_low_rdy <= tx_en && !tx_rdy;
        prev_en   <= tx_en;
        prev_data <= tx_data;
        if (stuck) begin
            tx_rdy <= 1'b1;
        end else if (hold) begin
            tx_rdy <= 1'b0;
            busy_left <= 0;
        end else if (!tx_rdy) begin
            if (busy_left == 0) tx_rdy <= 1'b1;
            else busy_left <= busy_left - 1;
        end else if (tx_en) begin
            rcv_q.push_back(tx_data);
            tx_rdy <= 1'b0;
            busy_left <= $urandom_range(bmax, bmin);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic push(input logic [7:0] b);
        wr_en = 1'b1;
        wr_data = b;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n;
        n = 0;
        while (!(rcv_q.size() >= exp_q.size() && empty && !tx_en && tx_rdy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_drain_timeout"}, (n < budget), 1);
    endtask

    task automatic check_stream(input string tag);
        chk({tag, "_count"}, rcv_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < rcv_q.size(); i++)
            chk($sformatf("%s_byte%0d", tag, i), rcv_q[i], exp_q[i]);
    endtask

    initial begin
        int n;
        int pending;
        logic [7:0] b;

        #40 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_level", level, 0);
        chk("rst_tx_en", tx_en, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_tx_stall", tx_stall, 0);
        chk("rst_tx_data", tx_data, 8'h00);

        // single byte: tx_en two cycles after the push
        exp_q.push_back(8'h55);
        push(8'h55);
        chk("single_en_lat1", tx_en, 0);
        chk("single_level", level, 1);
        @(negedge clk);
        chk("single_en_lat2", tx_en, 1);
        chk("single_data", tx_data, 8'h55);
        wait_drain("single", 200);
        chk("single_empty", empty, 1);

        // burst 01..05 on consecutive cycles
        for (int i = 1; i <= 5; i++) begin
            exp_q.push_back(8'(i));
            push(8'(i));
        end
        chk("burst_peak", (level >= 4 && level <= 5), 1);
        wait_drain("burst", 500);

        // random bytes, random gaps and random transmitter busy times
        bmin = 0;
        bmax = 25;
        for (int i = 0; i < 12; i++) begin
            b = 8'($urandom);
            exp_q.push_back(b);
            push(b);
            n = $urandom_range(3, 0);
            repeat (n) @(negedge clk);
        end
        wait_drain("random", 2000);
        bmin = 2;
        bmax = 10;

        // overflow with transmitter held busy
        hold = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 17; i++) begin
            b = 8'($urandom);
            pending = exp_q.size() - rcv_q.size();
            if (pending < DEPTH) exp_q.push_back(b);
            push(b);
            if (i == 15) begin
                chk("ovf_full16", full, 1);
                chk("ovf_flag16", overflow, 0);
            end
        end
        chk("ovf_flag17", overflow, 1);
        chk("ovf_level", level, 16);
        chk("ovf_full17", full, 1);
        clr_flags = 1'b1;
        @(negedge clk);
        clr_flags = 1'b0;
        chk("ovf_clear", overflow, 0);
        hold = 1'b0;
        wait_drain("ovf", 2000);

        // stalled transmitter
        stuck = 1'b1;
        exp_q.push_back(8'hA3);
        push(8'hA3);
        n = 0;
        while (!tx_en && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("stall_rise", tx_en, 1);
        n = 0;
        while (tx_en && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("stall_en_cycles", n, 64);
        chk("stall_flag", tx_stall, 1);
        chk("stall_gap", tx_en, 0);
        @(negedge clk);
        chk("stall_reraise", tx_en, 1);
        chk("stall_data", tx_data, 8'hA3);
        stuck = 1'b0;
        wait_drain("stall", 500);
        clr_flags = 1'b1;
        @(negedge clk);
        clr_flags = 1'b0;
        chk("stall_clear", tx_stall, 0);

        // reset while BUSY with three bytes queued
        bmin = 60;
        bmax = 60;
        for (int i = 0; i < 4; i++) begin
            b = 8'($urandom);
            exp_q.push_back(b);
            push(b);
        end
        n = 0;
        while (!(!tx_rdy && !tx_en && level == 3) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("rstmid_reach", (n < 50), 1);
        repeat (3) void'(exp_q.pop_back());
        #3 rst_n = 1'b0;
        #1;
        chk("rstmid_tx_en", tx_en, 0);
        chk("rstmid_level", level, 0);
        chk("rstmid_empty", empty, 1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (150) @(negedge clk);
        chk("rstmid_idle", tx_en, 0);

        check_stream("stream");
        chk("protocol_violations", violations, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/uart_tx_feeder.md
Name: uart_tx_feeder

Overview:
- Byte FIFO plus launch FSM that sits directly upstream of uart_tx.
- Accepts bytes from a producer (uart_echo datapath, command responder) at clock rate.
- Drives uart_tx's en/data_in pair one byte at a time, using uart_tx's rdy as the busy/idle indicator.
- Decouples bursty producers from the 9600-baud serialiser and flags lost bytes and a stalled transmitter.

Parameters:
- DEPTH, 16, FIFO entries; power of two, ≥2.
- ADDR_W, 4, log2(DEPTH).
- START_TIMEOUT, 64, max clk cycles en is held waiting for tx_rdy to fall before abort/retry.

Ports:
- clk  in  1  system clock (32 MHz nominal).
- rst  in  1  asynchronous reset, active-low; assertion immediately clears all state, deassertion is synchronised externally.
- wr_en  in  1  push request, one byte per cycle.
- wr_data  in  8  byte to push.
- full  out  1  FIFO holds DEPTH entries.
- empty  out  1  FIFO holds 0 entries.
- level  out  ADDR_W+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: push attempted while full.
- tx_stall  out  1  sticky: START_TIMEOUT expired at least once.
- clr_flags  in  1  synchronous clear of overflow and tx_stall.
- tx_en  out  1  to uart_tx en.
- tx_data  out  8  to uart_tx data_in; stable whenever tx_en=1 and until tx_rdy returns high.
- tx_rdy  in  1  from uart_tx rdy; 1 = idle.

Behaviour:
- Reset values:
  - full=0, empty=1, level=0, overflow=0, tx_stall=0, tx_en=0, tx_data=8'h00.
  - Pointers=0, FSM=IDLE, timeout counter=0.
- FIFO:
  - Circular buffer, registers or inferred RAM.
  - ADDR_W-bit pointers wrap DEPTH-1 → 0.
  - level is tracked as a separate counter.
  - Push accepted iff wr_en=1 and full=0 at that edge.
  - A push while full is dropped, sets overflow, and leaves contents unchanged.
  - Same-cycle pop and push (full=0) are both accepted; level is unchanged.
  - A push to an empty FIFO is visible to the FSM next cycle; minimum latency wr_en → tx_en = 2 cycles.
  - clr_flags has priority over a same-cycle set: the flag clears.
- FSM states: IDLE, START, BUSY.
- IDLE:
  - tx_en=0.
  - If empty=0 and tx_rdy=1: pop head into tx_data, go to START.
  - Otherwise stay in IDLE.
- START:
  - tx_en=1; timeout counter increments each cycle.
  - If tx_rdy=0: tx_en drops next cycle, counter is cleared, go to BUSY.
  - If counter reaches START_TIMEOUT-1 with tx_rdy still 1: set tx_stall, drop tx_en, go to IDLE_RETRY.
- IDLE_RETRY (fourth state):
  - tx_en=0 for 1 cycle, then return to START with the same tx_data.
  - The byte is not re-popped and is not lost.
- BUSY:
  - tx_en=0; wait for tx_rdy=1, then go to IDLE.
  - The next byte may launch on the following cycle.
- Exactly one pop per transmitted byte; tx_data changes only on a pop.
- Bytes are emitted in push order; no reordering or duplication.
- Reset mid-transmission (any state): FSM returns to IDLE and tx_en=0 immediately; FIFO contents are discarded. The in-flight uart_tx frame is uart_tx's responsibility.
- tx_rdy glitch-free assumption: it is registered in uart_tx, and no extra synchroniser is needed here.

Decomposition:
- Shared package (uart_pkg):
  - FSM state enum: IDLE, START, IDLE_RETRY, BUSY.
  - Default DEPTH and START_TIMEOUT constants.
  - SYSTEM_CLOCK/BAUD_RATE defaults, shared with uart_tx/uart_rx.
- One natural sub-module: sync_fifo (parameters DEPTH, ADDR_W; ports wr_en/wr_data/rd_en/rd_data/full/empty/level).
- The FSM and sticky flags live in uart_tx_feeder.

Test Plan:
- Bench setup: real uart_tx, SYSTEM_CLOCK=32 MHz, BAUD_RATE=9600, reset asserted low 40 ns.
- After reset: empty=1, level=0, tx_en=0, overflow=0, tx_stall=0.
- Single byte 8'h55: pushed → tx_en high 2 cycles later, tx_data=8'h55, until tx_rdy falls; serial line shows 0x55 frame; empty=1 afterwards.
- Burst of 8'h01..8'h05 on consecutive cycles:
  - level peaks at 5 or 4 (first pop may overlap).
  - Five frames appear in order 01,02,03,04,05.
  - Each launch occurs only after tx_rdy has returned high.
- Overflow with DEPTH=16, transmitter held busy:
  - Push 17 bytes → full=1 after the 16th, overflow=1 after the 17th, level=16.
  - Bytes 0..15 are transmitted; byte 16 is never seen.
  - clr_flags clears overflow.
- Stalled transmitter (tx_rdy model stuck at 1, ignores en), push 8'hA3:
  - tx_en high 64 cycles, then tx_stall=1, 1-cycle low, re-raised with tx_data=8'hA3.
  - Releasing the model completes the 0xA3 frame.
- Reset mid-frame: assert rst low during BUSY with 3 bytes queued → tx_en=0 and level=0 immediately; no further frames after release.
